phase_sequencer: RTL and testbench
==================================

// Module: phase_sequencer
// PURPOSE
//  Run-control block for the 5-phase instruction cycle. Drives the phase counter's
//  changeEnable to start, single-step, stop and halt the processor. Stalls phase 4
//  while memory is busy, counts retired instructions, and faults on bad phase or
//  memory timeout. Sits between the console/debug inputs and the phase counter.
// PARAMETERS
//  MEM_WAIT_MAX  15  consecutive phase-4 busy cycles tolerated before FAULT (1..255)
//  CNT_W         16  width of retired-instruction counter
// PORTS
//  clock         in   1      system clock; all state updates on posedge
//  reset         in   1      asynchronous, active-low reset
//  run_req       in   1      pulse: start free-running execution
//  step_req      in   1      pulse: execute exactly one instruction
//  stop_req      in   1      pulse: stop at next instruction boundary
//  halt_insn     in   1      decoded HLT; valid while phase[4]
//  mem_busy      in   1      memory not ready; honoured only in phase[3] (p4)
//  phase         in   5      one-hot {p5,p4,p3,p2,p1} from phase counter
//  change_enable out  1      advance enable to phase counter (combinational)
//  running       out  1      state is RUN or STEP
//  halted        out  1      state is HALT
//  fault         out  1      state is FAULT
//  instr_count   out  CNT_W  retired instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, instr_count=0, wait_cnt=0; all outputs 0.
//  States: IDLE, RUN, STEP, HALT, FAULT (registered, posedge clock).
//  change_enable = (state==RUN|STEP) & ~(phase[3] & mem_busy) & ~bkpt_block.
//  Boundary event: change_enable & phase[4] on a posedge -> instr_count+1 there.
//  IDLE: run_req->RUN; else step_req->STEP; run_req&step_req -> RUN wins.
//  RUN: stop_req->STEP (current instruction completes, then IDLE).
//  STEP: at boundary -> IDLE. run_req in STEP -> RUN (cancels pending stop).
//  At boundary with halt_insn=1 -> HALT (priority over stop/step->IDLE);
//   instruction still counted. HALT/FAULT exit only by reset; all reqs ignored.
//  wait_cnt (8b): +1 each cycle phase[3]&mem_busy in RUN/STEP, else cleared;
//   reaching MEM_WAIT_MAX -> FAULT next edge; change_enable=0 from then on.
//  In RUN/STEP, phase not one-hot (zero or >1 bit) -> FAULT next edge.
//  Phase is not checked in IDLE/HALT/FAULT. Reqs are single-cycle pulses;
//   level-held run_req in IDLE acts once (RUN is sticky).
//  Stop leaves phase counter at p1 of next instruction (no partial instruction).
// CONFIGURATION
//  PHASE_SEQ_BKPT_EN defined: adds ports bkpt_en in 1, bkpt_addr in 8, pc in 8,
//   bkpt_hit out 1 (sticky, cleared on run_req/step_req, reset 0).
//   In RUN with phase[0] & bkpt_en & pc==bkpt_addr & ~skip: bkpt_block=1 (no
//   advance), next edge -> IDLE, bkpt_hit=1. skip flag set on the IDLE->RUN/STEP
//   transition, cleared at next boundary, so resuming at the breakpoint proceeds.
//   STEP is never blocked.
//  Not defined: no extra ports, bkpt_block tied 0, identical otherwise.
// TESTING
//  Reset mid-RUN at p3 -> next cycle all outputs 0, state IDLE, instr_count=0.
//  step_req, mem_busy=0, counter model -> 5 change_enable cycles, instr_count=1, IDLE.
//  run_req; mem_busy=1 for 3 cycles in p4 -> change_enable low exactly 3 cycles,
//   no fault; MEM_WAIT_MAX=4 with busy held 4 -> fault=1, change_enable=0.
//  RUN, stop_req at p2 -> phases p3..p5 complete, instr_count+1, IDLE at p1.
//  halt_insn=1 in p5 with stop_req same cycle -> halted=1, run_req ignored.
//  Force phase=5'b00110 during RUN -> fault=1 next edge; instr_count unchanged.
//  BKPT_EN: bkpt_addr=8'h10, pc=8'h10 at p1 -> IDLE, bkpt_hit=1; run_req ->
//   instruction at 8'h10 executes, instr_count+1.

Source files
------------

// File: rtl/phase_sequencer.sv
// Run-control FSM for the 5-phase instruction cycle: start/step/stop/halt, memory stall, fault detect.
// Define PHASE_SEQ_BKPT_EN to add the PC breakpoint ports and logic.
module phase_sequencer #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             stop_req,
    input  logic             halt_insn,
    input  logic             mem_busy,
    input  logic [4:0]       phase,
`ifdef PHASE_SEQ_BKPT_EN
    input  logic             bkpt_en,
    input  logic [7:0]       bkpt_addr,
    input  logic [7:0]       pc,
    output logic             bkpt_hit,
`endif
    output logic             change_enable,
    output logic             running,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_HALT,
        S_FAULT
    } state_e;

    state_e           r_state;
    state_e           w_next;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_inc;
    logic [CNT_W-1:0] r_instr_count;
    logic             w_active;
    logic             w_onehot;
    logic             w_mem_stall;
    logic             w_boundary;
    logic             w_timeout;
    logic             w_bkpt_block;

    assign w_active    = (r_state == S_RUN) || (r_state == S_STEP);
    assign w_onehot    = (phase != 5'd0) && ((phase & (phase - 5'd1)) == 5'd0);
    assign w_mem_stall = phase[3] & mem_busy;
    assign w_wait_inc  = r_wait_cnt + 8'd1;
    assign w_timeout   = w_active & w_mem_stall & (w_wait_inc >= 8'(MEM_WAIT_MAX));

    assign change_enable = w_active & ~w_mem_stall & ~w_bkpt_block;
    assign w_boundary    = change_enable & phase[4];

`ifdef PHASE_SEQ_BKPT_EN
    logic r_skip;
    logic r_bkpt_hit;

    // Skip lets the instruction we resumed at get past its own breakpoint once.
    assign w_bkpt_block = (r_state == S_RUN) & phase[0] & bkpt_en & (pc == bkpt_addr) & ~r_skip;
    assign bkpt_hit     = r_bkpt_hit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_skip     <= 1'b0;
            r_bkpt_hit <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && ((w_next == S_RUN) || (w_next == S_STEP)))
                r_skip <= 1'b1;
            else if (w_boundary)
                r_skip <= 1'b0;

            if (w_bkpt_block)
                r_bkpt_hit <= 1'b1;
            else if (run_req || step_req)
                r_bkpt_hit <= 1'b0;
        end
    end
`else
    assign w_bkpt_block = 1'b0;
`endif

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (run_req)       w_next = S_RUN;
                else if (step_req) w_next = S_STEP;
            end
            S_RUN: begin
                if (!w_onehot || w_timeout)        w_next = S_FAULT;
                else if (w_boundary && halt_insn)  w_next = S_HALT;
                else if (w_bkpt_block)             w_next = S_IDLE;
                else if (w_boundary && stop_req)   w_next = S_IDLE;
                else if (stop_req)                 w_next = S_STEP;
            end
            S_STEP: begin
                if (!w_onehot || w_timeout)        w_next = S_FAULT;
                else if (w_boundary && halt_insn)  w_next = S_HALT;
                else if (run_req)                  w_next = S_RUN;
                else if (w_boundary)               w_next = S_IDLE;
            end
            default: w_next = r_state;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= 8'd0;
            r_instr_count <= '0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= (w_active && w_mem_stall) ? w_wait_inc : 8'd0;
            if (w_boundary)
                r_instr_count <= r_instr_count + 1'b1;
        end
    end

    assign running     = w_active;
    assign halted      = (r_state == S_HALT);
    assign fault       = (r_state == S_FAULT);
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer with a one-hot phase counter model driven by change_enable.
// Breakpoint scenario is compiled in when PHASE_SEQ_BKPT_EN is defined.
module tb_phase_sequencer;

    logic        clock;
    logic        reset;
    logic        run_req, step_req, stop_req, halt_insn, mem_busy;
    logic [4:0]  phase;
    logic [4:0]  ph_model;
    logic        force_en;
    logic [4:0]  force_val;
    logic        change_enable, running, halted, fault;
    logic [15:0] instr_count;
`ifdef PHASE_SEQ_BKPT_EN
    logic        bkpt_en;
    logic [7:0]  bkpt_addr;
    logic [7:0]  pc;
    logic        bkpt_hit;
`endif

    phase_sequencer #(.MEM_WAIT_MAX(4), .CNT_W(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .run_req      (run_req),
        .step_req     (step_req),
        .stop_req     (stop_req),
        .halt_insn    (halt_insn),
        .mem_busy     (mem_busy),
        .phase        (phase),
`ifdef PHASE_SEQ_BKPT_EN
        .bkpt_en      (bkpt_en),
        .bkpt_addr    (bkpt_addr),
        .pc           (pc),
        .bkpt_hit     (bkpt_hit),
`endif
        .change_enable(change_enable),
        .running      (running),
        .halted       (halted),
        .fault        (fault),
        .instr_count  (instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Phase counter model: rotates one-hot on each enabled edge.
    always @(posedge clock or negedge reset) begin
        if (!reset)             ph_model <= 5'b00001;
        else if (change_enable) ph_model <= {ph_model[3:0], ph_model[4]};
    end
    assign phase = force_en ? force_val : ph_model;

    typedef enum int {C_RUNNING, C_HALTED, C_FAULT, C_COUNT, C_CE, C_PHASE, C_HIT, C_MEAS} sel_e;
    typedef struct {
        string       name;
        sel_e        sel;
        logic [31:0] exp;
        logic [31:0] meas;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_sig(input string nm, input sel_e s, input logic [31:0] e);
        sb.push_back('{name: nm, sel: s, exp: e, meas: 32'd0});
    endtask

    task automatic expect_meas(input string nm, input logic [31:0] m, input logic [31:0] e);
        sb.push_back('{name: nm, sel: C_MEAS, exp: e, meas: m});
    endtask

    // Monitor: samples the DUT on the falling edge and drains pending expectations.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clock);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.sel)
                    C_RUNNING: act = {31'd0, running};
                    C_HALTED:  act = {31'd0, halted};
                    C_FAULT:   act = {31'd0, fault};
                    C_COUNT:   act = {16'd0, instr_count};
                    C_CE:      act = {31'd0, change_enable};
                    C_PHASE:   act = {27'd0, phase};
`ifdef PHASE_SEQ_BKPT_EN
                    C_HIT:     act = {31'd0, bkpt_hit};
`endif
                    default:   act = e.meas;
                endcase
                check(e.name, act, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_run();
        run_req = 1'b1; tick(); run_req = 1'b0;
    endtask

    task automatic pulse_step();
        step_req = 1'b1; tick(); step_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0; tick(); reset = 1'b1; tick();
    endtask

    task automatic wait_phase(input int idx, input string nm);
        int n;
        n = 0;
        while (!phase[idx] && n < 20) begin
            tick();
            n++;
        end
        if (!phase[idx]) expect_meas(nm, 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b0; run_req = 1'b0; step_req = 1'b0; stop_req = 1'b0;
        halt_insn = 1'b0; mem_busy = 1'b0; force_en = 1'b0; force_val = 5'd0;
`ifdef PHASE_SEQ_BKPT_EN
        bkpt_en = 1'b0; bkpt_addr = 8'h00; pc = 8'h00;
`endif
        tick(); tick();
        expect_sig("rst_running", C_RUNNING, 0);
        expect_sig("rst_halted",  C_HALTED,  0);
        expect_sig("rst_fault",   C_FAULT,   0);
        expect_sig("rst_count",   C_COUNT,   0);
        expect_sig("rst_ce",      C_CE,      0);
        tick();
        reset = 1'b1;
        tick();

        // Single step: exactly five enabled phases, one retired instruction.
        pulse_step();
        n = 0;
        repeat (8) begin
            @(negedge clock);
            if (change_enable) n++;
        end
        expect_meas("step_ce_cycles", n, 5);
        expect_sig("step_count",   C_COUNT,   1);
        expect_sig("step_running", C_RUNNING, 0);
        expect_sig("step_phase",   C_PHASE,   5'b00001);
        tick();

        // Three busy cycles in p4 stall without faulting (limit is 4).
        pulse_run();
        wait_phase(3, "wait_p4_stall");
        mem_busy = 1'b1;
        n = 0;
        repeat (3) begin
            @(negedge clock);
            if (!change_enable) n++;
            tick();
        end
        mem_busy = 1'b0;
        expect_meas("stall_ce_low", n, 3);
        expect_sig("stall_fault",   C_FAULT,   0);
        expect_sig("stall_ce_back", C_CE,      1);
        expect_sig("stall_running", C_RUNNING, 1);

        // Stop at p2: finish p3..p5, then IDLE at p1.
        wait_phase(1, "wait_p2_stop");
        expect_sig("stop_count_before", C_COUNT, 2);
        stop_req = 1'b1; tick(); stop_req = 1'b0;
        tick(); tick();
        expect_sig("stop_still_running", C_RUNNING, 1);
        tick();
        expect_sig("stop_idle",  C_RUNNING, 0);
        expect_sig("stop_count", C_COUNT,   3);
        expect_sig("stop_phase", C_PHASE,   5'b00001);
        tick();

        // HLT at p5 with simultaneous stop: HALT wins, later requests ignored.
        pulse_run();
        wait_phase(4, "wait_p5_halt");
        halt_insn = 1'b1; stop_req = 1'b1; tick();
        halt_insn = 1'b0; stop_req = 1'b0;
        pulse_run();
        pulse_step();
        expect_sig("halt_halted",  C_HALTED,  1);
        expect_sig("halt_running", C_RUNNING, 0);
        expect_sig("halt_count",   C_COUNT,   4);
        expect_sig("halt_ce",      C_CE,      0);
        tick();

        // Asynchronous reset in the middle of an instruction at p3.
        do_reset();
        pulse_run();
        wait_phase(4, "wait_p5_pre_rst");
        tick();
        expect_sig("pre_rst_count", C_COUNT, 1);
        wait_phase(2, "wait_p3_rst");
        reset = 1'b0;
        expect_sig("midrst_running", C_RUNNING, 0);
        expect_sig("midrst_halted",  C_HALTED,  0);
        expect_sig("midrst_fault",   C_FAULT,   0);
        expect_sig("midrst_count",   C_COUNT,   0);
        expect_sig("midrst_ce",      C_CE,      0);
        tick();
        reset = 1'b1;
        tick();

        // Non-one-hot phase while running faults on the next edge.
        pulse_run();
        tick();
        force_val = 5'b00110; force_en = 1'b1;
        tick();
        force_en = 1'b0;
        expect_sig("badph_fault",   C_FAULT,   1);
        expect_sig("badph_ce",      C_CE,      0);
        expect_sig("badph_count",   C_COUNT,   0);
        expect_sig("badph_running", C_RUNNING, 0);
        tick();

        // Memory busy held for four p4 cycles reaches the limit and faults.
        do_reset();
        pulse_run();
        wait_phase(3, "wait_p4_tmo");
        mem_busy = 1'b1;
        tick(); tick(); tick();
        expect_sig("tmo_fault_early", C_FAULT, 0);
        expect_sig("tmo_ce_early",    C_CE,    0);
        tick();
        expect_sig("tmo_fault", C_FAULT, 1);
        tick();
        mem_busy = 1'b0;
        expect_sig("tmo_ce_after", C_CE,    0);
        expect_sig("tmo_count",    C_COUNT, 0);
        tick();

`ifdef PHASE_SEQ_BKPT_EN
        // Breakpoint at 0x10: block at p1, resume executes that instruction once.
        do_reset();
        bkpt_en = 1'b1; bkpt_addr = 8'h10; pc = 8'h0f;
        pulse_run();
        pc = 8'h10;
        repeat (5) tick();
        expect_sig("bkpt_block_ce",  C_CE,      0);
        expect_sig("bkpt_block_cnt", C_COUNT,   1);
        tick();
        expect_sig("bkpt_idle",  C_RUNNING, 0);
        expect_sig("bkpt_hit",   C_HIT,     1);
        expect_sig("bkpt_phase", C_PHASE,   5'b00001);
        pulse_run();
        expect_sig("bkpt_hit_clr",   C_HIT, 0);
        expect_sig("bkpt_resume_ce", C_CE,  1);
        repeat (5) tick();
        tick();
        expect_sig("bkpt_resume_count", C_COUNT,   2);
        expect_sig("bkpt_rehit",        C_HIT,     1);
        expect_sig("bkpt_reidle",       C_RUNNING, 0);
        tick();
`endif

        repeat (3) @(negedge clock);
        if (sb.size() != 0) expect_meas("scoreboard_drained", sb.size(), 0);
        repeat (2) @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
